// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fpu_pkg                                                      |
// | Description : Shared FP rounding/exception encodings and response record.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fpu_pkg;

    localparam logic [1:0] FP_ROUND_RNE = 2'b00;
    localparam logic [1:0] FP_ROUND_RTZ = 2'b01;
    localparam logic [1:0] FP_ROUND_RDN = 2'b10;
    localparam logic [1:0] FP_ROUND_RUP = 2'b11;

    localparam int FP_EXC_WIDTH = 5;
    localparam logic [FP_EXC_WIDTH-1:0] FP_INVALID   = 5'b10000;
    localparam logic [FP_EXC_WIDTH-1:0] FP_DIVZERO   = 5'b01000;
    localparam logic [FP_EXC_WIDTH-1:0] FP_OVERFLOW  = 5'b00100;
    localparam logic [FP_EXC_WIDTH-1:0] FP_UNDERFLOW = 5'b00010;
    localparam logic [FP_EXC_WIDTH-1:0] FP_INEXACT   = 5'b00001;

    // Record is sized for the widest supported format; users zero-extend into it.
    localparam int FP_MAX_WIDTH = 64;
    localparam int FP_MAX_IDW   = 8;

    typedef struct packed {
        logic [FP_MAX_IDW-1:0]   id;
        logic [FP_MAX_WIDTH-1:0] result;
        logic [FP_EXC_WIDTH-1:0] exception;
    } fp_resp_t;

endpackage
`default_nettype wire

// File: rtl/fp_resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_resp_fifo                                                 |
// | Description : Synchronous FIFO of fp_resp_t entries with occupancy output. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fp_resp_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  fp_resp_t                 i_wr_data,
    input  logic                     i_rd_en,
    output fp_resp_t                 o_rd_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w+1)'(1);
    localparam logic [c_ptr_w:0]   c_full    = (c_ptr_w+1)'(DEPTH);

    fp_resp_t           r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_pop     = i_rd_en && !o_empty;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            assert (!(i_wr_en && o_full)) else $error("fp_resp_fifo: write while full");
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({i_wr_en, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_mul_arbiter                                               |
// | Description : Round-robin share of one 2-cycle FP multiplier, in-order     |
// |               tagged responses with credit-based backpressure.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fp_mul_arbiter
    import fpu_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  exp_width  = 8,
    parameter int  frac_width = 23,
    parameter int  RESP_DEPTH = 2,
    localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int FPW        = exp_width + frac_width + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*FPW-1:0] req_op1,
    input  logic [NUM_REQ*FPW-1:0] req_op2,
    input  logic [NUM_REQ*2-1:0]   req_round_mode,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [FPW-1:0]         resp_result,
    output logic [4:0]             resp_exception,
    output logic                   mul_en,
    output logic [FPW-1:0]         mul_op1,
    output logic [FPW-1:0]         mul_op2,
    output logic [1:0]             mul_round_mode,
    input  logic [FPW-1:0]         mul_result,
    input  logic [4:0]             mul_exception
);

    localparam int c_cnt_w = $clog2(RESP_DEPTH) + 1;
    localparam logic [c_cnt_w:0] c_depth   = (c_cnt_w+1)'(RESP_DEPTH);
    localparam logic [IDW-1:0]   c_last_id = IDW'(NUM_REQ - 1);

    if (NUM_REQ < 1 || IDW > FP_MAX_IDW || FPW > FP_MAX_WIDTH || RESP_DEPTH < 2
        || (RESP_DEPTH & (RESP_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("fp_mul_arbiter: unsupported parameterization");
    end

    logic [IDW-1:0]     r_rr_ptr;
    logic               r_s1_valid;
    logic [IDW-1:0]     r_s1_id;
    logic [IDW-1:0]     w_grant;
    logic [IDW-1:0]     w_next_ptr;
    int                 w_scan;
    logic               w_any;
    logic               w_pop;
    logic               w_can_issue;
    logic               w_issue;
    logic [c_cnt_w:0]   w_occ;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    fp_resp_t           w_wr_data;
    fp_resp_t           w_rd_data;
    logic               w_unused_rd;

    // Count the same-cycle pop so a 2-deep buffer sustains one op per cycle.
    assign w_pop       = resp_valid & resp_ready;
    assign w_occ       = {1'b0, w_fifo_count} + {{c_cnt_w{1'b0}}, r_s1_valid}
                         - {{c_cnt_w{1'b0}}, w_pop};
    assign w_can_issue = (w_occ < c_depth);
    assign w_issue     = !rst && w_can_issue && w_any;

    // Scan from the far end so the index closest to r_rr_ptr wins last.
    always_comb begin
        w_any  = 1'b0;
        w_scan = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_any  = 1'b1;
                w_scan = (int'(r_rr_ptr) + k) % NUM_REQ;
            end
        end
    end

    assign w_grant    = IDW'(w_scan);
    assign w_next_ptr = (w_grant == c_last_id) ? '0 : w_grant + IDW'(1);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_issue && (w_grant == IDW'(i));
        end
    end

    assign mul_en         = w_issue;
    assign mul_op1        = req_op1[int'(w_grant)*FPW +: FPW];
    assign mul_op2        = req_op2[int'(w_grant)*FPW +: FPW];
    assign mul_round_mode = req_round_mode[int'(w_grant)*2 +: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
        end else begin
            r_s1_valid <= w_issue;
            r_s1_id    <= w_grant;
            if (w_issue) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    always_comb begin
        w_wr_data           = '0;
        w_wr_data.id        = FP_MAX_IDW'(r_s1_id);
        w_wr_data.result    = FP_MAX_WIDTH'(mul_result);
        w_wr_data.exception = mul_exception;
    end

    fp_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (r_s1_valid),
        .i_wr_data (w_wr_data),
        .i_rd_en   (resp_ready),
        .o_rd_data (w_rd_data),
        .o_empty   (w_fifo_empty),
        .o_full    (w_fifo_full),
        .o_count   (w_fifo_count)
    );

    assign resp_valid     = !w_fifo_empty;
    assign resp_id        = w_rd_data.id[IDW-1:0];
    assign resp_result    = w_rd_data.result[FPW-1:0];
    assign resp_exception = w_rd_data.exception;
    assign w_unused_rd    = ^{w_rd_data, w_fifo_full};

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fp_mul_arbiter                                            |
// | Description : Directed self-checking bench with a stub 2-cycle multiplier. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fp_mul_arbiter;
    import fpu_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_op1;
    logic [N*W-1:0] req_op2;
    logic [N*2-1:0] req_round_mode;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_result;
    logic [4:0]     resp_exception;
    logic           mul_en;
    logic [W-1:0]   mul_op1;
    logic [W-1:0]   mul_op2;
    logic [1:0]     mul_round_mode;
    logic [W-1:0]   mul_result;
    logic [4:0]     mul_exception;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int r_ids[$];
    int r_cyc[$];
    int g_log[$];
    logic [W-1:0] r_res[$];
    logic [4:0]   r_exc[$];

    always #5 clk = ~clk;

    fp_mul_arbiter #(
        .NUM_REQ    (N),
        .exp_width  (8),
        .frac_width (23),
        .RESP_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op1        (req_op1),
        .req_op2        (req_op2),
        .req_round_mode (req_round_mode),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_result    (resp_result),
        .resp_exception (resp_exception),
        .mul_en         (mul_en),
        .mul_op1        (mul_op1),
        .mul_op2        (mul_op2),
        .mul_round_mode (mul_round_mode),
        .mul_result     (mul_result),
        .mul_exception  (mul_exception)
    );

    // Stub multiplier: known IEEE cases, otherwise an XOR tag for tracking.
    function automatic logic [36:0] mul_model(logic [31:0] a, logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            64'h3FC00000_40000000: return {5'b00000, 32'h40400000};
            64'h7F000000_7F000000: return {FP_OVERFLOW | FP_INEXACT, 32'h7F800000};
            64'h7F800000_00000000: return {FP_INVALID, 32'hFFC00000};
            default:               return {5'b00000, a ^ b};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mul_en) begin
            {mul_exception, mul_result} <= mul_model(mul_op1, mul_op2);
        end
    end

    // Sample just before the active edge, after all inputs have settled.
    always begin
        @(negedge clk);
        #4;
        cyc++;
        if (!rst && resp_valid && resp_ready) begin
            r_ids.push_back(int'(resp_id));
            r_res.push_back(resp_result);
            r_exc.push_back(resp_exception);
            r_cyc.push_back(cyc);
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && req_valid[i]) g_log.push_back(i);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        r_ids.delete(); r_cyc.delete(); g_log.delete(); r_res.delete(); r_exc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick(); tick();
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst = 1'b1; req_valid = '1; resp_ready = 1'b1;
        req_op1 = '0; req_op2 = '0; req_round_mode = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_mul_en", mul_en, 0);

        // Single op from requester 2.
        tick();
        req_valid = '0;
        req_op1[2*W +: W] = 32'h3FC00000; req_op2[2*W +: W] = 32'h40000000;
        req_round_mode[4 +: 2] = FP_ROUND_RNE;
        rst = 1'b0; req_valid = 4'b0100;
        clear_logs();
        @(negedge clk);
        check("single_ready", req_ready, 4'b0100);
        check("single_mul_en", mul_en, 1);
        check("single_op1", mul_op1, 32'h3FC00000);
        check("single_op2", mul_op2, 32'h40000000);
        tick(); req_valid = '0;
        @(negedge clk);
        check("single_lat1_valid", resp_valid, 0);
        tick();
        @(negedge clk);
        check("single_valid", resp_valid, 1);
        check("single_id", resp_id, 2);
        check("single_result", resp_result, 32'h40400000);
        check("single_exc", resp_exception, 0);
        tick();
        @(negedge clk);
        check("single_popped", resp_valid, 0);

        // Exceptional operands; rr_ptr=3 so requester 0 wins by wrap-around.
        tick();
        req_op1[0 +: W] = 32'h7F000000; req_op2[0 +: W] = 32'h7F000000;
        req_round_mode[0 +: 2] = FP_ROUND_RNE;
        req_op1[W +: W] = 32'h7F800000; req_op2[W +: W] = 32'h00000000;
        req_round_mode[2 +: 2] = FP_ROUND_RTZ;
        req_valid = 4'b0011;
        @(negedge clk);
        check("exc_grant0", req_ready, 4'b0001);
        tick(); req_valid = 4'b0010;
        @(negedge clk);
        check("exc_grant1", req_ready, 4'b0010);
        check("exc_rm1", mul_round_mode, FP_ROUND_RTZ);
        tick(); req_valid = '0;
        repeat (4) tick();
        check("exc_count", r_ids.size(), 3);
        if (r_ids.size() == 3) begin
            check("ovf_id", r_ids[1], 0);
            check("ovf_result", r_res[1], 32'h7F800000);
            check("ovf_exc", r_exc[1], FP_OVERFLOW | FP_INEXACT);
            check("nan_id", r_ids[2], 1);
            check("nan_result", r_res[2], 32'hFFC00000);
            check("nan_exc", r_exc[2], FP_INVALID);
        end

        // Streaming with all requesters valid.
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_op1[i*W +: W] = 32'h10 + i; req_op2[i*W +: W] = 32'h100;
        end
        req_valid = '1;
        repeat (8) tick();
        req_valid = '0;
        repeat (5) tick();
        check("stream_grants", g_log.size(), 8);
        check("stream_resps", r_ids.size(), 8);
        for (int k = 0; k < 8 && k < g_log.size() && k < r_ids.size(); k++) begin
            check("stream_grant_order", g_log[k], k % 4);
            check("stream_id", r_ids[k], k % 4);
            check("stream_result", r_res[k], 32'h110 + (k % 4));
            check("stream_no_gap", r_cyc[k] - r_cyc[0], k);
        end

        // Backpressure: exactly RESP_DEPTH accepts, then resume with the pop.
        do_reset();
        resp_ready = 1'b0; req_valid = '1;
        repeat (6) tick();
        @(negedge clk);
        check("bp_accepts", g_log.size(), 2);
        check("bp_ready_low", req_ready, 0);
        check("bp_hold_valid", resp_valid, 1);
        check("bp_hold_id", resp_id, 0);
        #1 resp_ready = 1'b1;
        #1 check("bp_resume_same_cycle", req_ready, 4'b0100);
        repeat (5) tick();
        req_valid = '0;
        repeat (6) tick();
        check("bp_total_grants", g_log.size(), 7);
        check("bp_total_resps", r_ids.size(), 7);
        for (int k = 0; k < r_ids.size() && k < g_log.size(); k++) begin
            check("bp_order", r_ids[k], g_log[k]);
            check("bp_grant_seq", g_log[k], k % 4);
        end

        // Reset with one op in s1 and one in the FIFO.
        do_reset();
        resp_ready = 1'b0; req_valid = 4'b0010;
        tick(); tick();
        rst = 1'b1; req_valid = '0;
        tick();
        @(negedge clk);
        check("midrst_resp_valid", resp_valid, 0);
        tick();
        rst = 1'b0; resp_ready = 1'b1;
        clear_logs();
        repeat (5) tick();
        check("midrst_no_stale", r_ids.size(), 0);
        req_valid = '1;
        @(negedge clk);
        check("midrst_rr_ptr0", req_ready, 4'b0001);
        tick(); req_valid = '0;
        repeat (4) tick();
        check("midrst_one_resp", r_ids.size(), 1);

        // Requester 1 held while requester 3 toggles.
        do_reset();
        for (int round = 0; round < 2; round++) begin
            req_valid = 4'b0010;
            repeat (3) tick();
            req_valid = 4'b1010;
            got = 1'b0;
            for (int k = 0; k < N && !got; k++) begin
                @(negedge clk);
                if (req_ready[3]) got = 1'b1;
                else tick();
            end
            check("no_starve_req3", got, 1);
            tick();
        end
        req_valid = '0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
